// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-layer blocks: LIF controller states,
// default layer geometry and a width-generic saturating adder.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FIRE  = 2'd2,
        WRITE = 2'd3
    } lif_state_t;

    localparam int DEF_TIME_STEPS   = 10;
    localparam int DEF_LAYER_SIZE   = 32;
    localparam int DEF_SPARSE_SIZE  = 240;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int DEF_MEM_WIDTH    = 16;
    localparam int DEF_THRESHOLD    = 64;
    localparam int DEF_BETA_SHIFT   = 3;

    // Operands arrive sign-extended to 32 bits; the sum is clamped to a signed width-bit range.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int unsigned        width
    );
        logic signed [32:0] s;
        logic signed [32:0] maxv;
        logic signed [32:0] minv;
        s    = $signed({a[31], a}) + $signed({b[31], b});
        maxv = (33'sd1 <<< (width - 1)) - 33'sd1;
        minv = -(33'sd1 <<< (width - 1));
        if (s > maxv) begin
            return maxv[31:0];
        end else if (s < minv) begin
            return minv[31:0];
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational leaky-integrate-and-fire step: leak, integrate the step's
// accumulated input, threshold and subtract-reset.
module lif_update
    import snn_pkg::*;
#(
    parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int BETA_SHIFT = DEF_BETA_SHIFT
) (
    input  logic signed [MEM_WIDTH-1:0] i_mem,
    input  logic signed [MEM_WIDTH-1:0] i_sum,
    output logic signed [MEM_WIDTH-1:0] o_mem,
    output logic                        o_fired
);

    logic signed [31:0] w_mem_ext;
    logic signed [31:0] w_leak_ext;
    logic signed [31:0] w_sum_ext;
    logic signed [31:0] w_kept;
    logic signed [31:0] w_m;

    // mem - leak never leaves the MEM_WIDTH range, so only the integrate step saturates
    assign w_mem_ext  = 32'(i_mem);
    assign w_leak_ext = 32'(i_mem >>> BETA_SHIFT);
    assign w_sum_ext  = 32'(i_sum);
    assign w_kept     = w_mem_ext - w_leak_ext;
    assign w_m        = sat_add(w_kept, w_sum_ext, MEM_WIDTH);

    assign o_fired = (w_m >= THRESHOLD);
    assign o_mem   = o_fired ? MEM_WIDTH'(w_m - THRESHOLD) : MEM_WIDTH'(w_m);

endmodule

// File: rtl/fc_lif_neuron.sv
// LIF neuron stage behind the FC event controller: fetches and accumulates
// weights per input spike, fires once per time step, writes the spike RAM.
module fc_lif_neuron
    import snn_pkg::*;
#(
    parameter int  TIME_STEPS      = DEF_TIME_STEPS,
    parameter int  LAYER_SIZE      = DEF_LAYER_SIZE,
    parameter int  SPARSE_SIZE     = DEF_SPARSE_SIZE,
    parameter int  WEIGHT_WIDTH    = DEF_WEIGHT_WIDTH,
    parameter int  MEM_WIDTH       = DEF_MEM_WIDTH,
    parameter int  THRESHOLD       = DEF_THRESHOLD,
    parameter int  BETA_SHIFT      = DEF_BETA_SHIFT,
    parameter int  BRAM_ADDR_WIDTH = $clog2(LAYER_SIZE * SPARSE_SIZE),
    localparam int SPK_AW          = $clog2(SPARSE_SIZE),
    localparam int NRN_W           = $clog2(LAYER_SIZE),
    localparam int TS_W            = $clog2(TIME_STEPS) + 2,
    localparam int CNT_W           = $clog2(LAYER_SIZE) + 1
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_frame_start,
    input  logic                                   i_en_accum,
    input  logic                                   i_en_activ,
    input  logic [SPK_AW-1:0]                      i_spk_addr,
    input  logic [NRN_W-1:0]                       i_neuron,
    input  logic [TS_W-1:0]                        i_spk_time_step,
    output logic                                   o_weight_rd_en,
    output logic [BRAM_ADDR_WIDTH-1:0]             o_weight_addr,
    input  logic signed [WEIGHT_WIDTH-1:0]         i_weight_data,
    output logic                                   o_spk_wr_en,
    output logic [TS_W-1:0]                        o_spk_wr_ts,
    output logic [NRN_W-1:0]                       o_spk_wr_neuron,
    output logic                                   o_spk_wr_bit,
    output logic                                   o_post_syn_spk,
    output logic                                   o_busy,
    output logic                                   o_overrun,
    output logic [TIME_STEPS-1:0][CNT_W-1:0]       o_total_spks_out
);

    localparam int TS_IDX_W = $clog2(TIME_STEPS);

    lif_state_t                       r_state;
    logic                             r_drain_wait;
    logic                             r_s2_valid;
    logic                             r_ts_valid;
    logic [NRN_W-1:0]                 r_neuron;
    logic [TS_W-1:0]                  r_ts;
    logic signed [MEM_WIDTH-1:0]      r_mem;
    logic signed [MEM_WIDTH-1:0]      r_sum;
    logic                             r_weight_rd_en;
    logic [BRAM_ADDR_WIDTH-1:0]       r_weight_addr;
    logic                             r_spk_wr_en;
    logic [TS_W-1:0]                  r_spk_wr_ts;
    logic [NRN_W-1:0]                 r_spk_wr_neuron;
    logic                             r_spk_wr_bit;
    logic                             r_post_syn_spk;
    logic                             r_overrun;
    logic [TIME_STEPS-1:0][CNT_W-1:0] r_total;

    logic [BRAM_ADDR_WIDTH-1:0]       w_addr;
    logic signed [MEM_WIDTH-1:0]      w_sum_next;
    logic signed [MEM_WIDTH-1:0]      w_new_mem;
    logic                             w_fired;
    logic                             w_strobe;
    logic                             w_new_neuron;
    logic                             w_ts_in_range;

    assign w_addr = BRAM_ADDR_WIDTH'(i_neuron) * BRAM_ADDR_WIDTH'(SPARSE_SIZE)
                  + BRAM_ADDR_WIDTH'(i_spk_addr);
    assign w_sum_next    = MEM_WIDTH'(sat_add(32'(r_sum), 32'(i_weight_data), MEM_WIDTH));
    assign w_strobe      = i_en_accum | i_en_activ;
    assign w_new_neuron  = (i_neuron != r_neuron);
    assign w_ts_in_range = (i_spk_time_step < TS_W'(TIME_STEPS));

    lif_update #(
        .MEM_WIDTH  (MEM_WIDTH),
        .THRESHOLD  (THRESHOLD),
        .BETA_SHIFT (BETA_SHIFT)
    ) u_lif_update (
        .i_mem   (r_mem),
        .i_sum   (r_sum),
        .o_mem   (w_new_mem),
        .o_fired (w_fired)
    );

    // Stage-2 accumulation sits ahead of the FSM so a FIRE-cycle clear of r_sum takes precedence
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= IDLE;
            r_drain_wait    <= 1'b0;
            r_s2_valid      <= 1'b0;
            r_ts_valid      <= 1'b0;
            r_neuron        <= '0;
            r_ts            <= '0;
            r_mem           <= '0;
            r_sum           <= '0;
            r_weight_rd_en  <= 1'b0;
            r_weight_addr   <= '0;
            r_spk_wr_en     <= 1'b0;
            r_spk_wr_ts     <= '0;
            r_spk_wr_neuron <= '0;
            r_spk_wr_bit    <= 1'b0;
            r_post_syn_spk  <= 1'b0;
            r_overrun       <= 1'b0;
            r_total         <= '0;
        end else if (i_frame_start) begin
            r_state        <= IDLE;
            r_drain_wait   <= 1'b0;
            r_s2_valid     <= 1'b0;
            r_weight_rd_en <= 1'b0;
            r_spk_wr_en    <= 1'b0;
            r_neuron       <= '0;
            r_mem          <= '0;
            r_sum          <= '0;
            r_overrun      <= 1'b0;
            r_total        <= '0;
        end else begin
            r_spk_wr_en    <= 1'b0;
            r_weight_rd_en <= 1'b0;
            r_s2_valid     <= r_weight_rd_en;
            if (r_s2_valid) begin
                r_sum <= w_sum_next;
            end
            if (r_state != IDLE && w_strobe) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_strobe && w_new_neuron) begin
                        r_neuron <= i_neuron;
                        r_mem    <= '0;
                    end
                    if (i_en_accum) begin
                        r_weight_rd_en <= 1'b1;
                        r_weight_addr  <= w_addr;
                    end
                    if (i_en_activ) begin
                        r_ts         <= i_spk_time_step;
                        r_ts_valid   <= w_ts_in_range;
                        r_drain_wait <= 1'b0;
                        r_state      <= DRAIN;
                        if (!w_ts_in_range) begin
                            r_overrun <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    r_drain_wait <= 1'b1;
                    if (r_drain_wait) begin
                        r_state <= FIRE;
                    end
                end
                FIRE: begin
                    r_mem          <= w_new_mem;
                    r_sum          <= '0;
                    r_post_syn_spk <= w_fired;
                    if (r_ts_valid) begin
                        r_spk_wr_en     <= 1'b1;
                        r_spk_wr_ts     <= r_ts;
                        r_spk_wr_neuron <= r_neuron;
                        r_spk_wr_bit    <= w_fired;
                        if (w_fired) begin
                            r_total[r_ts[TS_IDX_W-1:0]] <= r_total[r_ts[TS_IDX_W-1:0]] + CNT_W'(1);
                        end
                    end
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_weight_rd_en   = r_weight_rd_en;
    assign o_weight_addr    = r_weight_addr;
    assign o_spk_wr_en      = r_spk_wr_en;
    assign o_spk_wr_ts      = r_spk_wr_ts;
    assign o_spk_wr_neuron  = r_spk_wr_neuron;
    assign o_spk_wr_bit     = r_spk_wr_bit;
    assign o_post_syn_spk   = r_post_syn_spk;
    assign o_busy           = (r_state != IDLE);
    assign o_overrun        = r_overrun;
    assign o_total_spks_out = r_total;

endmodule

// File: tb/tb_fc_lif_neuron.sv
// Directed bench for fc_lif_neuron with a registered weight BRAM model and
// hand-computed membrane/spike expectations.
module tb_fc_lif_neuron;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 frameStart;
    logic                 enAccum;
    logic                 enActiv;
    logic [7:0]           spkAddr;
    logic [4:0]           neuron;
    logic [5:0]           spkTimeStep;
    logic                 weightRdEn;
    logic [12:0]          weightAddr;
    logic signed [7:0]    weightData = '0;
    logic                 spkWrEn;
    logic [5:0]           spkWrTs;
    logic [4:0]           spkWrNeuron;
    logic                 spkWrBit;
    logic                 postSynSpk;
    logic                 busy;
    logic                 overrun;
    logic [9:0][5:0]      totalSpks;

    logic signed [7:0]    wmem [0:7679];

    int testsRun  = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (weightRdEn) weightData <= wmem[weightAddr];
    end

    fc_lif_neuron dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_frame_start    (frameStart),
        .i_en_accum       (enAccum),
        .i_en_activ       (enActiv),
        .i_spk_addr       (spkAddr),
        .i_neuron         (neuron),
        .i_spk_time_step  (spkTimeStep),
        .o_weight_rd_en   (weightRdEn),
        .o_weight_addr    (weightAddr),
        .i_weight_data    (weightData),
        .o_spk_wr_en      (spkWrEn),
        .o_spk_wr_ts      (spkWrTs),
        .o_spk_wr_neuron  (spkWrNeuron),
        .o_spk_wr_bit     (spkWrBit),
        .o_post_syn_spk   (postSynSpk),
        .o_busy           (busy),
        .o_overrun        (overrun),
        .o_total_spks_out (totalSpks)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic sendSpike(input int nrn, input int addr);
        neuron  = 5'(nrn);
        spkAddr = 8'(addr);
        enAccum = 1'b1;
        tick();
        enAccum = 1'b0;
    endtask

    // Drives en_activ (optionally with a same-cycle spike), optionally injects a
    // spike injectCycle cycles later, and checks the write pulse and busy window.
    task automatic applyStimulus(input int nrn, input int ts, input int expBit,
                                 input int simAddr, input int injectCycle,
                                 input int injectAddr, input string tag);
        int   latency;
        int   seenBit;
        int   seenNrn;
        int   seenTs;
        int   seenPost;
        int   busyAt1;
        int   busyAt4;
        int   busyAt5;
        latency  = 0;
        seenBit  = -1;
        seenNrn  = -1;
        seenTs   = -1;
        seenPost = -1;
        busyAt4  = -1;
        busyAt5  = -1;
        neuron      = 5'(nrn);
        spkTimeStep = 6'(ts);
        enActiv     = 1'b1;
        if (simAddr >= 0) begin
            enAccum = 1'b1;
            spkAddr = 8'(simAddr);
        end
        tick();
        enActiv = 1'b0;
        enAccum = 1'b0;
        busyAt1 = int'(busy);
        for (int c = 1; c <= 8; c++) begin
            if (spkWrEn && latency == 0) begin
                latency  = c;
                seenBit  = int'(spkWrBit);
                seenNrn  = int'(spkWrNeuron);
                seenTs   = int'(spkWrTs);
                seenPost = int'(postSynSpk);
            end
            if (c == 4) busyAt4 = int'(busy);
            if (c == 5) busyAt5 = int'(busy);
            if (c == injectCycle) begin
                enAccum = 1'b1;
                spkAddr = 8'(injectAddr);
            end
            tick();
            enAccum = 1'b0;
        end
        checkOutput({tag, ".wrLatency"}, latency, 4);
        checkOutput({tag, ".wrBit"}, seenBit, expBit);
        checkOutput({tag, ".wrNeuron"}, seenNrn, nrn);
        checkOutput({tag, ".wrTs"}, seenTs, ts);
        checkOutput({tag, ".postSyn"}, seenPost, expBit);
        checkOutput({tag, ".busyN1"}, busyAt1, 1);
        checkOutput({tag, ".busyN4"}, busyAt4, 1);
        checkOutput({tag, ".busyN5"}, busyAt5, 0);
    endtask

    task automatic countWrites(input int cycles, output int writes);
        writes = 0;
        for (int c = 0; c < cycles; c++) begin
            if (spkWrEn) writes++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int writes;
        for (int i = 0; i < 7680; i++) wmem[i] = 8'sd0;
        wmem[485] = 8'sd40;
        wmem[487] = 8'sd30;
        wmem[480] = 8'sd127;
        wmem[491] = 8'sd100;
        wmem[720] = -8'sd20;
        wmem[721] = 8'sd100;

        rst = 1'b1; frameStart = 1'b0; enAccum = 1'b0; enActiv = 1'b0;
        spkAddr = '0; neuron = '0; spkTimeStep = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("reset.rdEn", int'(weightRdEn), 0);
        checkOutput("reset.addr", int'(weightAddr), 0);
        checkOutput("reset.wrEn", int'(spkWrEn), 0);
        checkOutput("reset.post", int'(postSynSpk), 0);
        checkOutput("reset.busy", int'(busy), 0);
        checkOutput("reset.overrun", int'(overrun), 0);
        checkOutput("reset.totals", int'(|totalSpks), 0);

        // neuron 2, ts 0: 40 + 30 = 70 fires, mem becomes 6
        sendSpike(2, 5);
        checkOutput("t1.rdEn", int'(weightRdEn), 1);
        checkOutput("t1.addr5", int'(weightAddr), 485);
        sendSpike(2, 7);
        checkOutput("t1.addr7", int'(weightAddr), 487);
        tick();
        applyStimulus(2, 0, 1, -1, 0, 0, "t1");
        checkOutput("t1.total0", int'(totalSpks[0]), 1);

        // ts 1, no input: 6 - (6>>>3) = 6, no fire
        applyStimulus(2, 1, 0, -1, 0, 0, "t2");
        checkOutput("t2.total1", int'(totalSpks[1]), 0);
        checkOutput("t2.overrun", int'(overrun), 0);

        // ts 2: weight-100 spike two cycles after en_activ must be dropped (m stays 6)
        applyStimulus(2, 2, 0, -1, 2, 11, "ovr");
        checkOutput("ovr.overrun", int'(overrun), 1);

        // ts 3: 300 x 127 saturates at 32767 -> fires, mem 32703
        for (int i = 0; i < 300; i++) sendSpike(2, 0);
        applyStimulus(2, 3, 1, -1, 0, 0, "sat");
        checkOutput("sat.total3", int'(totalSpks[3]), 1);
        // ts 4: 32703 - 4087 = 28616 fires only if the sum did not wrap
        applyStimulus(2, 4, 1, -1, 0, 0, "satLeak");
        checkOutput("satLeak.total4", int'(totalSpks[4]), 1);

        // neuron 3 with a simultaneous -20 spike: mem cleared, m = -20
        applyStimulus(3, 0, 0, 0, 0, 0, "nrn3");
        checkOutput("nrn3.total0", int'(totalSpks[0]), 1);

        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        checkOutput("frame.overrun", int'(overrun), 0);
        checkOutput("frame.totals", int'(|totalSpks), 0);

        // out-of-range time step: overrun, no write
        neuron = 5'd3; spkTimeStep = 6'd10; enActiv = 1'b1;
        tick();
        enActiv = 1'b0;
        checkOutput("badTs.overrun", int'(overrun), 1);
        countWrites(8, writes);
        checkOutput("badTs.writes", writes, 0);
        checkOutput("badTs.totals", int'(|totalSpks), 0);

        // neuron 3, ts 1: weight 100 fires (mem was 0)
        sendSpike(3, 1);
        applyStimulus(3, 1, 1, -1, 0, 0, "n3fire");
        checkOutput("n3fire.total1", int'(totalSpks[1]), 1);

        // reset during DRAIN aborts the step
        sendSpike(3, 1);
        neuron = 5'd3; spkTimeStep = 6'd2; enActiv = 1'b1;
        tick();
        enActiv = 1'b0;
        checkOutput("rst.busyDrain", int'(busy), 1);
        rst = 1'b1;
        tick();
        checkOutput("rst.busy", int'(busy), 0);
        checkOutput("rst.post", int'(postSynSpk), 0);
        checkOutput("rst.overrun", int'(overrun), 0);
        checkOutput("rst.totals", int'(|totalSpks), 0);
        checkOutput("rst.wrNeuron", int'(spkWrNeuron), 0);
        checkOutput("rst.wrBit", int'(spkWrBit), 0);
        checkOutput("rst.addr", int'(weightAddr), 0);
        checkOutput("rst.wrEn", int'(spkWrEn), 0);
        rst = 1'b0;
        countWrites(8, writes);
        checkOutput("rst.writes", writes, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/fc_lif_neuron.md
# fc_lif_neuron

Downstream companion of the FC event-control stage: consumes its per-spike address strobes (`en_accum`, `spk_addr`) and per-time-step activation strobes (`en_activ`). Fetches the matching synaptic weight from the layer weight BRAM and accumulates it into the current neuron's membrane. Applies leaky-integrate-and-fire dynamics once per time step. Writes resulting output spikes, bit-addressed, into the post-synaptic spike RAM, and keeps per-time-step output spike counts.

## Interface
- `TIME_STEPS`, 10, time steps per frame
- `LAYER_SIZE`, 32, neurons in this layer
- `SPARSE_SIZE`, 240, pre-synaptic inputs per neuron (channels × frame size)
- `WEIGHT_WIDTH`, 8, signed weight width
- `MEM_WIDTH`, 16, signed membrane/accumulator width
- `THRESHOLD`, 64, firing threshold (positive, fits `MEM_WIDTH`)
- `BETA_SHIFT`, 3, leak = mem >>> BETA_SHIFT
- `BRAM_ADDR_WIDTH`, $clog2(LAYER_SIZE*SPARSE_SIZE), weight address width

Ports:
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — synchronous, active-high
- `frame_start` in 1 — pulse: clear membrane, counters, error flag
- `en_accum` in 1 — one valid spike address this cycle
- `en_activ` in 1 — end of current time step for current neuron
- `spk_addr` in $clog2(SPARSE_SIZE) — pre-synaptic index of spike
- `neuron` in $clog2(LAYER_SIZE) — current neuron
- `spk_time_step` in $clog2(TIME_STEPS)+2 — current time step
- `weight_rd_en` out 1, `weight_addr` out BRAM_ADDR_WIDTH — weight BRAM read port
- `weight_data` in WEIGHT_WIDTH — read data, valid one cycle after `weight_rd_en`
- `spk_wr_en` out 1, `spk_wr_ts` out $clog2(TIME_STEPS)+2, `spk_wr_neuron` out $clog2(LAYER_SIZE), `spk_wr_bit` out 1 — spike RAM bit write
- `post_syn_spk` out 1 — fired flag of last activation, held
- `busy` out 1 — high outside IDLE
- `overrun` out 1 — sticky: strobe arrived while busy
- `total_spks_out` out [TIME_STEPS] × ($clog2(LAYER_SIZE)+1) — spikes per time step

## Operation
- `weight_addr = neuron*SPARSE_SIZE + spk_addr`, computed at full BRAM_ADDR_WIDTH, registered.
- Accumulate pipeline:
  - stage 1: `en_accum` registers address and `weight_rd_en`.
  - stage 2: `weight_data` sign-extended to MEM_WIDTH and added to `sum`, saturating.
- FSM states: IDLE, DRAIN, FIRE, WRITE.
  - IDLE: accepts `en_accum` back-to-back. `en_activ` → DRAIN. Simultaneous `en_accum` and `en_activ`: the spike is accumulated first, then drained.
  - DRAIN: wait until both pipeline stages are empty (2 cycles) → FIRE.
  - FIRE:
    - `m = mem - (mem >>> BETA_SHIFT) + sum`, saturating to signed MEM_WIDTH.
    - If `m >= THRESHOLD`: fire, `mem = m - THRESHOLD`. Otherwise `mem = m`.
    - `sum` cleared; → WRITE.
  - WRITE: pulse `spk_wr_en` with ts/neuron latched at `en_activ`, `spk_wr_bit` = fired. Update `post_syn_spk`. If fired, `total_spks_out[ts]++`. → IDLE.
- New neuron: when the latched neuron differs from `neuron` at the first strobe, `mem` is cleared to 0 before use.
- Any `en_accum`/`en_activ` while `busy` is dropped and sets `overrun`.
- `spk_time_step >= TIME_STEPS` at `en_activ`: no counter update, no write; sets `overrun`.
- `frame_start` has priority over strobes in the same cycle: FSM → IDLE, pipeline flushed.

## Timing
- Reset values (all outputs 0):
  - `weight_rd_en`, `weight_addr`, `spk_wr_en`, `spk_wr_ts`, `spk_wr_neuron`, `spk_wr_bit`, `post_syn_spk`, `busy`, `overrun`, every `total_spks_out`.
  - Internally `mem`, `sum`, and latched neuron are 0; FSM is IDLE.
- `en_accum` at cycle N: `weight_rd_en` at N+1, `weight_data` sampled at N+2, `sum` updated visible at N+3.
- `en_activ` at cycle N, last `en_accum` ≤ N: DRAIN N+1..N+2, FIRE N+3, `spk_wr_en` pulse and `post_syn_spk` at N+4, `busy` low from N+5.
- Upstream guarantee: ≥4 idle cycles between `en_activ` and the next strobe. Violation → `overrun`.
- `rst` mid-operation aborts within one cycle; no write issued.

## Structure
- Shared package `snn_pkg`: `lif_state_t` enum (IDLE, DRAIN, FIRE, WRITE), saturating-add function, width helper constants.
- Sub-module `lif_update`: combinational leak/integrate/threshold/subtract-reset. Parameterised MEM_WIDTH, THRESHOLD, BETA_SHIFT; outputs new mem and fired. The FSM, accumulator, and counters stay in `fc_lif_neuron`.

## Test plan
- Neuron 2, ts 0, spikes at addr 5, 7 with weights 40, 30, then `en_activ` → `weight_addr` 485, 487; `spk_wr_bit`=1 at ts 0 / neuron 2; mem=6; `total_spks_out[0]`=1.
- Same neuron, ts 1, no spikes, `en_activ` only → m = 6 - 0 + 0 = 6; no fire; `spk_wr_en` pulse with bit 0.
- Weights 127 × 300 back-to-back (MEM_WIDTH 16) → sum saturates at 32767, no wrap; fires.
- `en_accum` two cycles after `en_activ` → dropped; `overrun`=1; `sum` unaffected.
- Neuron switches from 2 to 3 at ts 0 → mem cleared; a −20 weight yields m = −20, no fire.
- `rst` asserted during DRAIN → next cycle all outputs 0; no `spk_wr_en`; `frame_start` clears counters.
